// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared direction constants and modulo next-count helper for counters
package updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // max_val is MODULUS-1, so a 2**32 modulus still fits in 32 bits.
    function automatic logic [31:0] next_count_mod(
        input logic [31:0] cur,
        input logic        dir,
        input logic [31:0] max_val
    );
        if (dir == DIR_UP) begin
            return (cur >= max_val) ? 32'd0 : cur + 32'd1;
        end
        return (cur == 32'd0) ? max_val : cur - 32'd1;
    endfunction

endpackage

// File: rtl/updown_mod_counter_next.sv
// rtl/updown_mod_counter_next.sv - combinational next-count, wrap and terminal-count unit (UPDOWN_MOD_COUNTER_SATURATE_EN)
module updown_mod_counter_next
    import updown_counter_pkg::*;
#(
    parameter int          WIDTH   = 8,
    parameter logic [32:0] MODULUS = 33'd256
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_up_dn,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count_next,
    output logic             o_wrap_next,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MODULUS - 33'd1);

    logic [WIDTH-1:0] w_step;

    assign o_tc   = (i_up_dn == DIR_UP) ? (i_count == MAX_W) : (i_count == '0);
    assign w_step = WIDTH'(next_count_mod(32'(i_count), i_up_dn, 32'(MAX_W)));

    always_comb begin
        o_count_next = i_count;
        o_wrap_next  = 1'b0;
        if (i_load) begin
            o_count_next = (i_load_val > MAX_W) ? MAX_W : i_load_val;
        end else if (i_en) begin
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
            if (!o_tc) begin
                o_count_next = w_step;
            end
`else
            o_count_next = w_step;
            o_wrap_next  = o_tc;
`endif
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - modulo-N up/down counter with load, tc and wrap pulse (UPDOWN_MOD_COUNTER_SATURATE_EN)
module updown_mod_counter
    import updown_counter_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter logic [32:0] MODULUS   = 33'd256,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap_next;
    logic             w_tc;

    updown_mod_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .i_count      (r_count),
        .i_up_dn      (up_dn),
        .i_en         (en),
        .i_load       (load),
        .i_load_val   (load_val),
        .o_count_next (w_count_next),
        .o_wrap_next  (w_wrap_next),
        .o_tc         (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= RST_W;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign tc    = w_tc;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - directed table-driven bench for updown_mod_counter (UPDOWN_MOD_COUNTER_SATURATE_EN)
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] count;
    logic       tc;
    logic       wrap;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       ld;
        logic [2:0] lv;
        logic       en;
        logic       up;
        logic [2:0] cnt;
        logic       wr;
        logic       tc;
        logic [2:0] scnt;
        logic       stc;
    } vec_t;

    vec_t vecs[$];

    updown_mod_counter #(
        .WIDTH     (3),
        .MODULUS   (33'd6),
        .RESET_VAL (0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [2:0] lv, input logic e, input logic u,
                       input logic [2:0] c, input logic w, input logic t,
                       input logic [2:0] sc, input logic st);
        vec_t v;
        v.ld = ld; v.lv = lv; v.en = e; v.up = u;
        v.cnt = c; v.wr = w; v.tc = t; v.scnt = sc; v.stc = st;
        vecs.push_back(v);
    endtask

    task automatic step(input string name, input logic ld, input logic [2:0] lv, input logic e,
                        input logic u, input logic [2:0] c, input logic w, input logic t);
        load = ld; load_val = lv; en = e; up_dn = u;
        @(posedge clk);
        #1;
        chk({name, ".count"}, 32'(count), 32'(c));
        chk({name, ".wrap"},  32'(wrap),  32'(w));
        chk({name, ".tc"},    32'(tc),    32'(t));
    endtask

    initial begin
        // ld lv en up | count wrap tc | saturate count tc
        add(0,0,1,0, 5,1,0, 0,1);
        add(1,5,0,0, 5,0,0, 5,0);
        add(0,0,1,0, 4,0,0, 4,0);
        add(0,0,1,0, 3,0,0, 3,0);
        add(0,0,1,0, 2,0,0, 2,0);
        add(0,0,1,0, 1,0,0, 1,0);
        add(0,0,1,0, 0,0,1, 0,1);
        add(0,0,1,0, 5,1,0, 0,1);
        add(1,0,0,1, 0,0,0, 0,0);
        add(0,0,1,1, 1,0,0, 1,0);
        add(0,0,1,1, 2,0,0, 2,0);
        add(0,0,1,1, 3,0,0, 3,0);
        add(0,0,1,1, 4,0,0, 4,0);
        add(0,0,1,1, 5,0,1, 5,1);
        add(0,0,1,1, 0,1,0, 5,1);
        add(1,3,1,1, 3,0,0, 3,0);
        add(1,7,1,1, 5,0,1, 5,1);
        add(1,1,1,1, 1,0,0, 1,0);
        add(1,6,0,0, 5,0,0, 5,0);
        add(1,2,0,1, 2,0,0, 2,0);
        add(0,0,0,1, 2,0,0, 2,0);
        add(0,0,0,1, 2,0,0, 2,0);
        add(0,0,0,1, 2,0,0, 2,0);
        add(0,0,1,1, 3,0,0, 3,0);
        add(0,0,1,1, 4,0,0, 4,0);
        add(0,0,1,0, 3,0,0, 3,0);
        add(0,0,0,0, 3,0,0, 3,0);
        add(1,0,0,0, 0,0,1, 0,1);
        add(0,0,0,0, 0,0,1, 0,1);
        add(0,0,1,0, 5,1,0, 0,1);
        add(0,0,0,0, 5,0,0, 0,1);

        reset = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = 3'd0;
        #9;
        chk("reset.count", 32'(count), 32'd0);
        chk("reset.wrap",  32'(wrap),  32'd0);
        chk("reset.tc",    32'(tc),    32'd1);
        #3;
        reset = 1'b0;

        foreach (vecs[i]) begin
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
            step($sformatf("vec%0d", i), vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].up,
                 vecs[i].scnt, 1'b0, vecs[i].stc);
`else
            step($sformatf("vec%0d", i), vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].up,
                 vecs[i].cnt, vecs[i].wr, vecs[i].tc);
`endif
        end

        // Asynchronous reset between edges at count=4, held across edges with load and en active.
        step("rst_pre", 1, 3'd4, 0, 1, 3'd4, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async.count", 32'(count), 32'd0);
        chk("rst_async.wrap",  32'(wrap),  32'd0);
        load = 1'b1; load_val = 3'd3; en = 1'b1; up_dn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold.count", 32'(count), 32'd0);
        reset = 1'b0;
        step("rst_release", 0, 3'd0, 1, 1, 3'd1, 0, 0);

        // Reset clears a pending wrap pulse without waiting for clk.
        step("wrap_pre_ld", 1, 3'd5, 0, 1, 3'd5, 0, 1);
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
        step("wrap_pre_up", 0, 3'd0, 1, 1, 3'd5, 0, 1);
`else
        step("wrap_pre_up", 0, 3'd0, 1, 1, 3'd0, 1, 0);
`endif
        #2;
        reset = 1'b1;
        #1;
        chk("rst_wrap.wrap",  32'(wrap),  32'd0);
        chk("rst_wrap.count", 32'(count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
        step("sat_up_ld", 1, 3'd4, 0, 1, 3'd4, 0, 0);
        step("sat_up1",   0, 3'd0, 1, 1, 3'd5, 0, 1);
        step("sat_up2",   0, 3'd0, 1, 1, 3'd5, 0, 1);
        step("sat_up3",   0, 3'd0, 1, 1, 3'd5, 0, 1);
        step("sat_dn_ld", 1, 3'd1, 0, 0, 3'd1, 0, 0);
        step("sat_dn1",   0, 3'd0, 1, 0, 3'd0, 0, 1);
        step("sat_dn2",   0, 3'd0, 1, 0, 3'd0, 0, 1);
`else
        step("mod_up_ld", 1, 3'd4, 0, 1, 3'd4, 0, 0);
        step("mod_up1",   0, 3'd0, 1, 1, 3'd5, 0, 1);
        step("mod_up2",   0, 3'd0, 1, 1, 3'd0, 1, 0);
        step("mod_up3",   0, 3'd0, 1, 1, 3'd1, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
